trace_request_queue: RTL and testbench

Timestamped request queue between the trace-file front end and the DDR5 command scheduler. It accepts parsed trace entries over a valid/ready stream and buffers them in a parametrised circular FIFO. It keeps a free-running CPU-cycle counter and releases each entry only once the counter has reached the entry's timestamp. On release it presents the 34-bit physical address already decoded into DDR5 channel / bank group / bank / row / column fields.

---
 rtl/trace_request_queue.sv | 218 +++++++++++++++++++++
 tb/tb_trace_request_queue.sv | 473 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_request_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : trace_request_queue                                          |
// | Description : Timestamped request queue between the trace-file front end  |
// |               and the DDR5 command scheduler. Parsed trace entries are    |
// |               buffered in a circular FIFO and each one is released only   |
// |               once the free-running CPU-cycle counter has reached its     |
// |               timestamp. The released head entry's physical address is    |
// |               presented decoded into channel/bank group/bank/row/column.  |
// |                                                                            |
// | Ports       : clk_i, rst_ni        clock, async active-low reset          |
// |               in_*_i / in_ready_o  valid/ready entry input stream         |
// |               ff_en_i              fast-forward idle time to head stamp   |
// |               out_*_o / out_ready_i valid/ready decoded head output       |
// |               count_o              queue occupancy                        |
// |               cpu_time_o           CPU-cycle counter                      |
// |               order_err_o          sticky: out-of-order timestamp dropped |
// |               opn_err_o            sticky: illegal opcode dropped         |
// |                                                                            |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module trace_request_queue #(
  parameter int DEPTH      = 16,
  parameter int TIME_WIDTH = 64,
  parameter int CORE_WIDTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  // entry input stream
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [TIME_WIDTH-1:0]     in_time_i,
  input  logic [CORE_WIDTH-1:0]     in_core_i,
  input  logic [1:0]                in_opn_i,
  input  logic [33:0]               in_addr_i,
  input  logic                      ff_en_i,
  // released head entry
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [TIME_WIDTH-1:0]     out_time_o,
  output logic [CORE_WIDTH-1:0]     out_core_o,
  output logic [1:0]                out_opn_o,
  output logic [15:0]               out_row_o,
  output logic [9:0]                out_col_o,
  output logic [1:0]                out_bank_o,
  output logic [2:0]                out_bg_o,
  output logic                      out_chan_o,
  // status
  output logic [$clog2(DEPTH):0]    count_o,
  output logic [TIME_WIDTH-1:0]     cpu_time_o,
  output logic                      order_err_o,
  output logic                      opn_err_o
);

  localparam int c_PTR_W  = $clog2(DEPTH);
  localparam int c_CNT_W  = c_PTR_W + 1;
  // addr[1:0] is never needed downstream, so only addr[33:2] is stored
  localparam int c_ADDR_W = 32;
  localparam int c_ENT_W  = TIME_WIDTH + CORE_WIDTH + 2 + c_ADDR_W;

  localparam logic [c_CNT_W-1:0]    c_FULL     = c_CNT_W'(DEPTH);
  localparam logic [c_PTR_W-1:0]    c_LAST_IDX = c_PTR_W'(DEPTH - 1);
  localparam logic [TIME_WIDTH-1:0] c_TIME_MAX = '1;
  localparam logic [1:0]            c_OPN_ILL  = 2'd3;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [c_ENT_W-1:0]    mem_q [DEPTH];
  logic [c_PTR_W-1:0]    head_q, head_d;
  logic [c_PTR_W-1:0]    tail_q, tail_d;
  logic [c_CNT_W-1:0]    count_q, count_d;
  logic [TIME_WIDTH-1:0] cpu_time_q, cpu_time_d;
  logic [TIME_WIDTH-1:0] last_time_q, last_time_d;
  logic                  order_err_q, order_err_d;
  logic                  opn_err_q, opn_err_d;
  // copy of the most recently displayed head so outputs hold once drained
  logic [c_ENT_W-1:0]    hold_q, hold_d;

  // --------------------------------------------------------------------------
  // Combinational view of the head and handshakes
  // --------------------------------------------------------------------------
  logic                  w_not_empty;
  logic [c_ENT_W-1:0]    w_head_ent;
  logic [TIME_WIDTH-1:0] w_head_time;
  logic [c_ENT_W-1:0]    w_disp_ent;
  logic [c_ENT_W-1:0]    w_in_ent;
  logic                  w_push_hs;
  logic                  w_bad_opn;
  logic                  w_bad_order;
  logic                  w_store;
  logic                  w_pop;
  logic                  w_out_valid;
  logic [c_ADDR_W-1:0]   w_disp_addr;
  logic                  w_unused_addr;

  assign w_not_empty = (count_q != '0);
  assign w_head_ent  = mem_q[head_q];
  assign w_head_time = w_head_ent[c_ENT_W-1 -: TIME_WIDTH];
  assign w_in_ent    = {in_time_i, in_core_i, in_opn_i, in_addr_i[33:2]};
  assign w_unused_addr = ^in_addr_i[1:0];

  assign in_ready_o  = (count_q != c_FULL);
  assign w_push_hs   = in_valid_i && in_ready_o;
  assign w_bad_opn   = (in_opn_i == c_OPN_ILL);
  assign w_bad_order = (in_time_i < last_time_q);
  // bad entries still complete the handshake but never reach storage
  assign w_store     = w_push_hs && !w_bad_opn && !w_bad_order;

  assign w_out_valid = w_not_empty && (w_head_time <= cpu_time_q);
  assign w_pop       = w_out_valid && out_ready_i;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    cpu_time_d  = cpu_time_q;
    last_time_d = last_time_q;
    order_err_d = order_err_q;
    opn_err_d   = opn_err_q;
    hold_d      = hold_q;

    if (w_pop) begin
      head_d = (head_q == c_LAST_IDX) ? '0 : head_q + c_PTR_W'(1);
    end

    if (w_store) begin
      tail_d      = (tail_q == c_LAST_IDX) ? '0 : tail_q + c_PTR_W'(1);
      last_time_d = in_time_i;
    end

    case ({w_store, w_pop})
      2'b10:   count_d = count_q + c_CNT_W'(1);
      2'b01:   count_d = count_q - c_CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (w_push_hs && w_bad_opn) begin
      opn_err_d = 1'b1;
    end
    if (w_push_hs && w_bad_order) begin
      order_err_d = 1'b1;
    end

    // fast-forward jumps over idle time straight to a future-dated head
    if (ff_en_i && w_not_empty && (w_head_time > cpu_time_q)) begin
      cpu_time_d = w_head_time;
    end else if (cpu_time_q != c_TIME_MAX) begin
      cpu_time_d = cpu_time_q + TIME_WIDTH'(1);
    end

    if (w_not_empty) begin
      hold_d = w_head_ent;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      cpu_time_q  <= '0;
      last_time_q <= '0;
      order_err_q <= 1'b0;
      opn_err_q   <= 1'b0;
      hold_q      <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      cpu_time_q  <= cpu_time_d;
      last_time_q <= last_time_d;
      order_err_q <= order_err_d;
      opn_err_q   <= opn_err_d;
      hold_q      <= hold_d;
    end
  end

  // Entry storage carries no reset; occupancy alone defines what is valid.
  always_ff @(posedge clk_i) begin
    if (w_store) begin
      mem_q[tail_q] <= w_in_ent;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs and DDR5 address decode
  // --------------------------------------------------------------------------
  // The live head is shown while entries exist; otherwise the last shown
  // entry is held (zero straight out of reset).
  assign w_disp_ent  = w_not_empty ? w_head_ent : hold_q;
  assign w_disp_addr = w_disp_ent[c_ADDR_W-1:0];

  assign out_valid_o = w_out_valid;
  assign out_time_o  = w_disp_ent[c_ENT_W-1 -: TIME_WIDTH];
  assign out_core_o  = w_disp_ent[c_ADDR_W+2 +: CORE_WIDTH];
  assign out_opn_o   = w_disp_ent[c_ADDR_W +: 2];

  // stored bit k corresponds to physical address bit k+2
  assign out_row_o   = w_disp_addr[31:16];                    // addr[33:18]
  assign out_col_o   = {w_disp_addr[15:10], w_disp_addr[3:0]}; // {addr[17:12], addr[5:2]}
  assign out_bank_o  = w_disp_addr[9:8];                      // addr[11:10]
  assign out_bg_o    = w_disp_addr[7:5];                      // addr[9:7]
  assign out_chan_o  = w_disp_addr[4];                        // addr[6]

  assign count_o     = count_q;
  assign cpu_time_o  = cpu_time_q;
  assign order_err_o = order_err_q;
  assign opn_err_o   = opn_err_q;

endmodule
`default_nettype wire

// File: tb/tb_trace_request_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_trace_request_queue                                       |
// | Description : Self-checking bench for trace_request_queue: directed       |
// |               scenarios plus a randomized run against a queue-based       |
// |               reference model of the release/drop/counter rules.          |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module tb_trace_request_queue;

  localparam int DEPTH = 16;

  typedef struct {
    logic [63:0] t;
    logic [3:0]  core;
    logic [1:0]  opn;
    logic [33:0] addr;
  } ent_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_time;
  logic [3:0]  in_core;
  logic [1:0]  in_opn;
  logic [33:0] in_addr;
  logic        ff_en;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_time;
  logic [3:0]  out_core;
  logic [1:0]  out_opn;
  logic [15:0] out_row;
  logic [9:0]  out_col;
  logic [1:0]  out_bank;
  logic [2:0]  out_bg;
  logic        out_chan;
  logic [4:0]  count;
  logic [63:0] cpu_time;
  logic        order_err;
  logic        opn_err;

  int n_total = 0;
  int n_bad   = 0;

  trace_request_queue #(
    .DEPTH      (DEPTH),
    .TIME_WIDTH (64),
    .CORE_WIDTH (4)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_time_i   (in_time),
    .in_core_i   (in_core),
    .in_opn_i    (in_opn),
    .in_addr_i   (in_addr),
    .ff_en_i     (ff_en),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_time_o  (out_time),
    .out_core_o  (out_core),
    .out_opn_o   (out_opn),
    .out_row_o   (out_row),
    .out_col_o   (out_col),
    .out_bank_o  (out_bank),
    .out_bg_o    (out_bg),
    .out_chan_o  (out_chan),
    .count_o     (count),
    .cpu_time_o  (cpu_time),
    .order_err_o (order_err),
    .opn_err_o   (opn_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one cycle; sampling and driving happen 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_time   = '0;
    in_core   = '0;
    in_opn    = '0;
    in_addr   = '0;
    ff_en     = 1'b0;
    out_ready = 1'b0;
  endtask

  // leaves the DUT out of reset with cpu_time = 0 at the sample point
  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic push_set(input logic [63:0] t, input logic [3:0] c,
                          input logic [1:0] o, input logic [33:0] a);
    in_valid = 1'b1;
    in_time  = t;
    in_core  = c;
    in_opn   = o;
    in_addr  = a;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    n_total++;
    if ({count, in_ready, out_valid} !== {5'd0, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_state: count/in_ready/out_valid got %0d/%0b/%0b want 0/1/0",
               count, in_ready, out_valid);
    end
    n_total++;
    if ({cpu_time, order_err, opn_err, out_row} !== {64'd0, 1'b0, 1'b0, 16'd0}) begin
      n_bad++;
      $display("FAIL reset_zero: cpu=%0d oerr=%0b perr=%0b row=%h want zeros",
               cpu_time, order_err, opn_err, out_row);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_total++;
      if (cpu_time !== 64'(k)) begin
        n_bad++;
        $display("FAIL reset_count_up: cpu_time got %0d want %0d", cpu_time, k);
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_timed_release();
    do_reset();
    tick();
    tick();
    push_set(64'd10, 4'd3, 2'd1, 34'h3_FFFF_FFFF);
    tick();
    in_valid = 1'b0;
    n_total++;
    if ({count, out_time} !== {5'd1, 64'd10}) begin
      n_bad++;
      $display("FAIL timed_enqueue: count=%0d out_time=%0d want 1/10", count, out_time);
    end
    for (int k = 3; k <= 9; k++) begin
      n_total++;
      if ({cpu_time, out_valid} !== {64'(k), 1'b0}) begin
        n_bad++;
        $display("FAIL timed_wait: cpu=%0d out_valid=%0b want %0d/0", cpu_time, out_valid, k);
      end
      tick();
    end
    n_total++;
    if ({cpu_time, out_valid} !== {64'd10, 1'b1}) begin
      n_bad++;
      $display("FAIL timed_release: cpu=%0d out_valid=%0b want 10/1", cpu_time, out_valid);
    end
    n_total++;
    if ({out_row, out_col, out_bank, out_bg, out_chan, out_core, out_opn} !==
        {16'hFFFF, 10'h3FF, 2'd3, 3'd7, 1'b1, 4'd3, 2'd1}) begin
      n_bad++;
      $display("FAIL timed_decode: row=%h col=%h bank=%0d bg=%0d chan=%0b core=%0d opn=%0d",
               out_row, out_col, out_bank, out_bg, out_chan, out_core, out_opn);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_total++;
    if ({count, out_valid, out_row, out_time} !== {5'd0, 1'b0, 16'hFFFF, 64'd10}) begin
      n_bad++;
      $display("FAIL timed_pop_hold: count=%0d valid=%0b row=%h time=%0d want 0/0/ffff/10",
               count, out_valid, out_row, out_time);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_full_wrap();
    logic [33:0] a;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      a = 34'(i) << 18;
      push_set(64'd0, 4'(i), 2'(i % 3), a);
      n_total++;
      if (in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL fill_ready: in_ready got %0b want 1 at entry %0d", in_ready, i);
      end
      tick();
    end
    in_valid = 1'b0;
    n_total++;
    if ({count, in_ready, out_valid, out_row} !== {5'd16, 1'b0, 1'b1, 16'd0}) begin
      n_bad++;
      $display("FAIL full_state: count=%0d in_ready=%0b valid=%0b row=%0d want 16/0/1/0",
               count, in_ready, out_valid, out_row);
    end
    // offered push is refused while full; only the pop happens
    a = 34'd16 << 18;
    push_set(64'd0, 4'd0, 2'd0, a);
    out_ready = 1'b1;
    tick();
    n_total++;
    if ({count, out_row} !== {5'd15, 16'd1}) begin
      n_bad++;
      $display("FAIL full_pop: count=%0d row=%0d want 15/1", count, out_row);
    end
    for (int i = 16; i <= 19; i++) begin
      a = 34'(i) << 18;
      push_set(64'd0, 4'd0, 2'd0, a);
      tick();
      n_total++;
      if ({count, out_row} !== {5'd15, 16'(i - 14)}) begin
        n_bad++;
        $display("FAIL wrap_steady: count=%0d row=%0d want 15/%0d", count, out_row, i - 14);
      end
    end
    in_valid = 1'b0;
    for (int r = 5; r <= 19; r++) begin
      n_total++;
      if ({out_valid, out_row} !== {1'b1, 16'(r)}) begin
        n_bad++;
        $display("FAIL wrap_order: valid=%0b row=%0d want 1/%0d", out_valid, out_row, r);
      end
      tick();
    end
    out_ready = 1'b0;
    n_total++;
    if ({count, out_valid, out_row} !== {5'd0, 1'b0, 16'd19}) begin
      n_bad++;
      $display("FAIL wrap_drained: count=%0d valid=%0b row=%0d want 0/0/19", count, out_valid, out_row);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_fast_forward();
    do_reset();
    for (int k = 0; k < 5; k++) tick();
    push_set(64'd1000, 4'd1, 2'd2, 34'h1234);
    ff_en = 1'b1;
    tick();
    in_valid = 1'b0;
    n_total++;
    if ({cpu_time, count, out_valid} !== {64'd6, 5'd1, 1'b0}) begin
      n_bad++;
      $display("FAIL ff_accept: cpu=%0d count=%0d valid=%0b want 6/1/0", cpu_time, count, out_valid);
    end
    tick();
    ff_en = 1'b0;
    n_total++;
    if ({cpu_time, out_valid, out_time} !== {64'd1000, 1'b1, 64'd1000}) begin
      n_bad++;
      $display("FAIL ff_jump: cpu=%0d valid=%0b time=%0d want 1000/1/1000", cpu_time, out_valid, out_time);
    end
    tick();
    n_total++;
    if (cpu_time !== 64'd1001) begin
      n_bad++;
      $display("FAIL ff_resume: cpu=%0d want 1001", cpu_time);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_errors();
    do_reset();
    push_set(64'd50, 4'd2, 2'd0, 34'h100);
    tick();
    n_total++;
    if ({count, order_err, opn_err} !== {5'd1, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL err_first: count=%0d oerr=%0b perr=%0b want 1/0/0", count, order_err, opn_err);
    end
    push_set(64'd40, 4'd2, 2'd0, 34'h200);
    n_total++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL err_ready: in_ready got %0b want 1", in_ready);
    end
    tick();
    n_total++;
    if ({count, order_err, opn_err, out_time} !== {5'd1, 1'b1, 1'b0, 64'd50}) begin
      n_bad++;
      $display("FAIL err_order: count=%0d oerr=%0b perr=%0b time=%0d want 1/1/0/50",
               count, order_err, opn_err, out_time);
    end
    push_set(64'd60, 4'd2, 2'd3, 34'h300);
    tick();
    in_valid = 1'b0;
    n_total++;
    if ({count, opn_err, order_err} !== {5'd1, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL err_opn: count=%0d perr=%0b oerr=%0b want 1/1/1", count, opn_err, order_err);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push_set(64'd0, 4'd0, 2'd0, 34'(i) << 18);
      tick();
    end
    push_set(64'd5, 4'd0, 2'd0, 34'h40);
    tick();
    push_set(64'd1, 4'd0, 2'd0, 34'h80);
    tick();
    push_set(64'd7, 4'd0, 2'd3, 34'hC0);
    tick();
    in_valid = 1'b0;
    n_total++;
    if ({count, out_valid, order_err, opn_err} !== {5'd5, 1'b1, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL mid_setup: count=%0d valid=%0b oerr=%0b perr=%0b want 5/1/1/1",
               count, out_valid, order_err, opn_err);
    end
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({count, out_valid, cpu_time, order_err, opn_err} !== {5'd0, 1'b0, 64'd0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL mid_async: count=%0d valid=%0b cpu=%0d oerr=%0b perr=%0b want zeros",
               count, out_valid, cpu_time, order_err, opn_err);
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_total++;
    if ({count, out_valid, cpu_time, order_err, opn_err, in_ready} !==
        {5'd0, 1'b0, 64'd1, 1'b0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL mid_after: count=%0d valid=%0b cpu=%0d oerr=%0b perr=%0b rdy=%0b want 0/0/1/0/0/1",
               count, out_valid, cpu_time, order_err, opn_err, in_ready);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_random();
    ent_t        mq[$];
    ent_t        hold;
    ent_t        cur;
    ent_t        e;
    logic [63:0] m_cpu;
    logic [63:0] m_last;
    logic [63:0] nxt_cpu;
    logic        m_oerr;
    logic        m_perr;
    logic        exp_ready;
    logic        exp_valid;
    logic        pop;
    logic        bad_o;
    logic        bad_t;
    logic [15:0] e_row;
    logic [9:0]  e_col;
    logic [1:0]  e_bank;
    logic [2:0]  e_bg;
    logic        e_chan;

    do_reset();
    hold   = '{t: 64'd0, core: 4'd0, opn: 2'd0, addr: 34'd0};
    m_cpu  = 64'd0;
    m_last = 64'd0;
    m_oerr = 1'b0;
    m_perr = 1'b0;

    for (int cyc = 0; cyc < 1500; cyc++) begin
      // stimulus
      in_valid = ($urandom_range(0, 9) < 5);
      if (m_last >= 64'd5 && $urandom_range(0, 9) == 0)
        in_time = m_last - 64'($urandom_range(1, 5));
      else
        in_time = m_last + 64'($urandom_range(0, 25));
      in_core   = 4'($urandom_range(0, 15));
      in_opn    = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      in_addr   = {2'($urandom_range(0, 3)), 32'($urandom())};
      ff_en     = ($urandom_range(0, 19) == 0);
      out_ready = ($urandom_range(0, 9) < 7);

      // expectations from the model
      exp_ready = (mq.size() != DEPTH);
      exp_valid = (mq.size() != 0) && (mq[0].t <= m_cpu);
      cur       = (mq.size() != 0) ? mq[0] : hold;
      e_row  = 16'(cur.addr >> 18);
      e_col  = 10'((((cur.addr >> 12) % 64) * 16) + ((cur.addr >> 2) % 16));
      e_bank = 2'((cur.addr >> 10) % 4);
      e_bg   = 3'((cur.addr >> 7) % 8);
      e_chan = 1'((cur.addr >> 6) % 2);

      n_total++;
      if ({in_ready, out_valid} !== {exp_ready, exp_valid}) begin
        n_bad++;
        $display("FAIL rnd_hs cyc %0d: in_ready/out_valid got %0b/%0b want %0b/%0b",
                 cyc, in_ready, out_valid, exp_ready, exp_valid);
      end
      n_total++;
      if ({count, cpu_time} !== {5'(mq.size()), m_cpu}) begin
        n_bad++;
        $display("FAIL rnd_cnt cyc %0d: count/cpu got %0d/%0d want %0d/%0d",
                 cyc, count, cpu_time, mq.size(), m_cpu);
      end
      n_total++;
      if ({order_err, opn_err} !== {m_oerr, m_perr}) begin
        n_bad++;
        $display("FAIL rnd_err cyc %0d: oerr/perr got %0b/%0b want %0b/%0b",
                 cyc, order_err, opn_err, m_oerr, m_perr);
      end
      n_total++;
      if ({out_time, out_core, out_opn} !== {cur.t, cur.core, cur.opn}) begin
        n_bad++;
        $display("FAIL rnd_head cyc %0d: time/core/opn got %0d/%0d/%0d want %0d/%0d/%0d",
                 cyc, out_time, out_core, out_opn, cur.t, cur.core, cur.opn);
      end
      n_total++;
      if ({out_row, out_col, out_bank, out_bg, out_chan} !== {e_row, e_col, e_bank, e_bg, e_chan}) begin
        n_bad++;
        $display("FAIL rnd_decode cyc %0d: row/col/bank/bg/chan got %h/%h/%0d/%0d/%0b want %h/%h/%0d/%0d/%0b",
                 cyc, out_row, out_col, out_bank, out_bg, out_chan, e_row, e_col, e_bank, e_bg, e_chan);
      end

      // model update for this clock edge
      pop = exp_valid && out_ready;
      if (ff_en && mq.size() != 0 && mq[0].t > m_cpu)
        nxt_cpu = mq[0].t;
      else if (m_cpu != 64'hFFFF_FFFF_FFFF_FFFF)
        nxt_cpu = m_cpu + 64'd1;
      else
        nxt_cpu = m_cpu;
      if (mq.size() != 0) hold = mq[0];
      if (pop) void'(mq.pop_front());
      if (in_valid && exp_ready) begin
        bad_o = (in_opn == 2'd3);
        bad_t = (in_time < m_last);
        if (bad_o) m_perr = 1'b1;
        if (bad_t) m_oerr = 1'b1;
        if (!bad_o && !bad_t) begin
          e = '{t: in_time, core: in_core, opn: in_opn, addr: in_addr};
          mq.push_back(e);
          m_last = in_time;
        end
      end
      m_cpu = nxt_cpu;
      tick();
    end
    idle_inputs();
  endtask

  // --------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #2;
    test_reset();
    test_timed_release();
    test_full_wrap();
    test_fast_forward();
    test_errors();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
